// File: rtl/asm_pkg.sv
// asm_pkg: shared FSM state encoding and default sizing for the ASM driver
package asm_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD_BN,
    LOAD_W,
    LOAD_PIX,
    CALC,
    COLLECT,
    FLUSH
  } state_t;
  localparam int DEF_IMG_WIDTH   = 16;
  localparam int DEF_BN_WIDTH    = 16;
  localparam int DEF_N_BN        = 4;
  localparam int DEF_N_WWORDS    = 8;
  localparam int DEF_N_PIX       = 16;
  localparam int DEF_CALC_CYCLES = 32;
  localparam int DEF_N_OUT       = 32;
  localparam int WORD_W          = 16;
  localparam int CNT_W           = 16;
endpackage

// File: rtl/asm_bit_packer.sv
// asm_bit_packer: packs serial bits LSB-first into 16-bit words behind a valid/ready port
//   clk, rst (async, active-low)
//   i_bit_valid / i_bit : one result bit per strobe
//   o_valid / i_ready / o_data : completed word, held until accepted
module asm_bit_packer
  import asm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bit_valid,
  input  logic              i_bit,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_data
);
  localparam int IW = $clog2(WORD_W);
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_data;
  logic [IW-1:0]     r_idx;
  logic              r_valid;
  logic              w_done;
  assign w_done  = i_bit_valid && (r_idx == IW'(WORD_W - 1));
  assign o_valid = r_valid;
  assign o_data  = r_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_bit_valid) begin
        r_acc[r_idx] <= i_bit;
        r_idx        <= r_idx + 1'b1;
      end
      if (w_done) r_data <= {i_bit, r_acc[WORD_W-2:0]};
      // a word completing in the same cycle as a handshake keeps valid high
      r_valid <= w_done || (r_valid && !i_ready);
    end
  end
endmodule

// File: rtl/asm_driver.sv
// asm_driver: streams BN, weight and pixel words into the ASM, runs it, and collects its serial result
//   clk, rst (async, active-low), start
//   in_valid / in_ready / in_data   : host word stream
//   out_valid / out_ready / out_data: packed 16-bit result words
//   busy, asm_reception, asm_send, calculate_en, data_weights, data_pix, data_bn: ASM control/data
//   data_out: ASM serial result, valid one cycle after asm_send
module asm_driver
  import asm_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int BN_WIDTH    = DEF_BN_WIDTH,
  parameter int N_BN        = DEF_N_BN,
  parameter int N_WWORDS    = DEF_N_WWORDS,
  parameter int N_PIX       = DEF_N_PIX,
  parameter int CALC_CYCLES = DEF_CALC_CYCLES,
  parameter int N_OUT       = DEF_N_OUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMG_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic                 busy,
  output logic                 asm_reception,
  output logic                 asm_send,
  output logic                 calculate_en,
  output logic                 data_weights,
  output logic [IMG_WIDTH-1:0] data_pix,
  output logic [BN_WIDTH-1:0]  data_bn,
  input  logic                 data_out
);
  localparam int SW = $clog2(IMG_WIDTH + 1);
  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [SW-1:0]        r_sh_cnt;
  logic [IMG_WIDTH-1:0] r_shift;
  logic [IMG_WIDTH-1:0] r_pix;
  logic [BN_WIDTH-1:0]  r_bn;
  logic                 r_wbit;
  logic                 r_reception;
  logic                 r_send_d;
  logic                 w_acc;
  assign w_acc         = in_valid && in_ready;
  assign asm_reception = r_reception;
  assign data_weights  = r_wbit;
  assign data_pix      = r_pix;
  assign data_bn       = r_bn;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? LOAD_BN : IDLE;
      LOAD_BN:  w_next = (w_acc && r_cnt == CNT_W'(N_BN - 1)) ? LOAD_W : LOAD_BN;
      // leave once every word is taken and its last bit is on the line
      LOAD_W:   w_next = (r_cnt == CNT_W'(N_WWORDS) && r_sh_cnt == '0) ? LOAD_PIX : LOAD_W;
      LOAD_PIX: w_next = (w_acc && r_cnt == CNT_W'(N_PIX - 1)) ? CALC : LOAD_PIX;
      CALC:     w_next = (r_cnt == CNT_W'(CALC_CYCLES - 1)) ? COLLECT : CALC;
      COLLECT:  w_next = (asm_send && r_cnt == CNT_W'(N_OUT - 1)) ? FLUSH : COLLECT;
      // wait for the last in-flight bit and the final word handshake
      FLUSH:    w_next = (out_valid && out_ready && !r_send_d) ? IDLE : FLUSH;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    busy         = r_state != IDLE;
    calculate_en = r_state == CALC;
    in_ready     = (r_state == LOAD_BN) || (r_state == LOAD_PIX) ||
                   (r_state == LOAD_W && r_sh_cnt == '0 && r_cnt < CNT_W'(N_WWORDS));
    // at most one bit is in flight, and only the 16th bit can complete a word,
    // so stalling requests while the output is blocked never overruns the packer
    asm_send     = (r_state == COLLECT) && !(out_valid && !out_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_sh_cnt    <= '0;
      r_shift     <= '0;
      r_pix       <= '0;
      r_bn        <= '0;
      r_wbit      <= 1'b0;
      r_reception <= 1'b0;
      r_send_d    <= 1'b0;
    end else begin
      r_cnt       <= (w_next != r_state) ? '0 :
                     (w_acc || calculate_en || asm_send) ? r_cnt + 1'b1 : r_cnt;
      r_send_d    <= asm_send;
      r_reception <= w_acc || r_sh_cnt != '0;
      if (w_acc && r_state == LOAD_BN) r_bn <= in_data;
      if (w_acc && r_state == LOAD_PIX) r_pix <= in_data;
      if (w_acc && r_state == LOAD_W) begin
        r_wbit   <= in_data[0];
        r_shift  <= in_data >> 1;
        r_sh_cnt <= SW'(IMG_WIDTH - 1);
      end else if (r_sh_cnt != '0) begin
        r_wbit   <= r_shift[0];
        r_shift  <= r_shift >> 1;
        r_sh_cnt <= r_sh_cnt - 1'b1;
      end
    end
  end
  asm_bit_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_bit_valid (r_send_d),
    .i_bit       (data_out),
    .i_ready     (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_data)
  );
endmodule

// File: tb/tb_asm_driver.sv
// tb_asm_driver: table-driven frames with input/output scoreboards for asm_driver
module tb_asm_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        data_out = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, busy, asm_reception, asm_send, calculate_en, data_weights;
  logic [15:0] out_data, data_pix, data_bn;
  int n_pass = 0;
  int n_total = 0;

  asm_driver dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .asm_reception (asm_reception),
    .asm_send      (asm_send),
    .calculate_en  (calculate_en),
    .data_weights  (data_weights),
    .data_pix      (data_pix),
    .data_bn       (data_bn),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          stall;
    bit          gap;
    logic [15:0] e0;
    logic [15:0] e1;
  } row_t;

  exp_t        exp_in[$];
  logic [15:0] exp_out[$];
  int cnt_bn = 0, cnt_w = 0, cnt_pix = 0, cnt_calc = 0, cnt_out = 0;
  logic [31:0] model_bits = '0;
  int   m_idx = 0;
  logic m_s = 1'b0;
  row_t rows[4];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void miss(string name);
    n_total++;
    $display("FAIL %s: event did not occur as required", name);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (calculate_en) cnt_calc++;
    if (asm_reception) begin
      if (exp_in.size() == 0) miss("unexpected_strobe");
      else begin
        e = exp_in.pop_front();
        case (e.kind)
          0:       begin cnt_bn++;  chk("data_bn", data_bn, e.val); end
          1:       begin cnt_w++;   chk("data_weights", data_weights, e.val); end
          default: begin cnt_pix++; chk("data_pix", data_pix, e.val); end
        endcase
      end
    end
    if (out_valid && out_ready) begin
      cnt_out++;
      if (exp_out.size() == 0) miss("unexpected_word");
      else chk("out_data", out_data, exp_out.pop_front());
    end
  end

  always begin
    @(negedge clk);
    m_s = asm_send;
    @(posedge clk);
    #1;
    if (!busy) m_idx = 0;
    if (m_s && m_idx < 32) begin
      data_out = model_bits[m_idx];
      m_idx++;
    end
  end

  task automatic put(input logic [15:0] w, input int kind);
    int   t;
    exp_t e;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) miss("in_ready");
    else if (kind == 1) begin
      for (int b = 0; b < 16; b++) begin
        e.kind = 1;
        e.val  = {15'd0, w[b]};
        exp_in.push_back(e);
      end
    end else begin
      e.kind = kind;
      e.val  = w;
      exp_in.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input row_t r);
    int b_bn, b_w, b_pix, b_calc, b_out, t;
    b_bn = cnt_bn; b_w = cnt_w; b_pix = cnt_pix; b_calc = cnt_calc; b_out = cnt_out;
    model_bits = {r.w1, r.w0};
    exp_out.push_back(r.e0);
    exp_out.push_back(r.e1);
    out_ready = (r.stall == 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 1; i <= 4; i++) put(16'(i), 0);
    for (int i = 0; i < 8; i++) put(16'hA5A5, 1);
    for (int i = 0; i < 16; i++) begin
      put(16'h0010 + 16'(i), 2);
      if (r.gap) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (r.stall > 0) begin
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 500) begin
        t++;
        @(negedge clk);
      end
      if (!out_valid) miss("first_word");
      for (int c = 0; c < r.stall; c++) begin
        chk("stall_send", asm_send, 0);
        chk("stall_hold", out_data, r.e0);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    t = 0;
    while (busy && t < 2000) begin
      t++;
      @(posedge clk);
      #1;
    end
    if (busy) miss("frame_end");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
    chk("bn_strobes", cnt_bn - b_bn, 4);
    chk("weight_bits", cnt_w - b_w, 128);
    chk("pix_strobes", cnt_pix - b_pix, 16);
    chk("calc_cycles", cnt_calc - b_calc, 32);
    chk("out_words", cnt_out - b_out, 2);
    chk("in_left", exp_in.size(), 0);
    chk("out_left", exp_out.size(), 0);
  endtask

  initial begin
    rows[0] = '{16'hBEEF, 16'h1234, 0,  1'b0, 16'hBEEF, 16'h1234};
    rows[1] = '{16'hBEEF, 16'h1234, 10, 1'b0, 16'hBEEF, 16'h1234};
    rows[2] = '{16'hBEEF, 16'h1234, 0,  1'b1, 16'hBEEF, 16'h1234};
    rows[3] = '{16'h8001, 16'h7FFE, 1,  1'b1, 16'h8001, 16'h7FFE};
    @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, busy, asm_reception, asm_send, calculate_en,
                          data_weights, data_pix, data_bn, out_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) put(16'(i), 0);
    put(16'hA5A5, 1);
    put(16'hA5A5, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_shift", asm_reception, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midframe_reset", {in_ready, out_valid, busy, asm_reception, asm_send, calculate_en,
                           data_weights, data_pix, data_bn, out_data}, 0);
    exp_in.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_restart", busy, 0);
    for (int i = 0; i < 4; i++) run_frame(rows[i]);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
